booth_mult8_ctrl: RTL

Issue/retire controller placed directly in front of the iterative `booth_mult8` radix-8 multiplier core. It accepts operand requests on a valid/ready stream and buffers them in a small FIFO. It issues one request at a time to the core with a single-cycle `start` pulse, waits for the core's `done` pulse, and presents the registered 16-bit product with its request tag on a valid/ready output stream. The core ignores `start` while busy, so this block is the only place that sequences requests into it.

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_ctrl_fifo.sv | 60 ++++++
 rtl/booth_mult8_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths and FSM state encoding for the booth_mult8 controller
package booth_pkg;

    localparam int OP_W        = 8;
    localparam int PROD_W      = 16;
    localparam int SIGN_MODE_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/booth_ctrl_fifo.sv
// rtl/booth_ctrl_fifo.sv - request buffer with full/empty flags and head output
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, wdata      write request (ignored when full, even if popping)
//   pop              remove head entry (ignored when empty)
//   rdata            current head entry
//   full, empty      occupancy flags
module booth_ctrl_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/booth_mult8_ctrl.sv
// rtl/booth_mult8_ctrl.sv - issue/retire controller in front of the booth_mult8 core
//
// Optional feature macro: BOOTH_CTRL_TIMEOUT_EN (WAIT watchdog, out_err reporting).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              request stream handshake
//   in_a, in_b, in_sign_mode       operands and sign mode ([1]=a signed, [0]=b signed)
//   in_tag                         opaque request tag
//   mul_start                      one-cycle start pulse to the core
//   mul_a, mul_b, mul_sign_mode    operands to the core
//   mul_product, mul_done          core result and completion pulse
//   out_valid/out_ready            result stream handshake
//   out_product, out_tag, out_err  registered result, its tag, watchdog flag
module booth_mult8_ctrl
    import booth_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_a,
    input  logic [OP_W-1:0]        in_b,
    input  logic [SIGN_MODE_W-1:0] in_sign_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   mul_start,
    output logic [OP_W-1:0]        mul_a,
    output logic [OP_W-1:0]        mul_b,
    output logic [SIGN_MODE_W-1:0] mul_sign_mode,
    input  logic [PROD_W-1:0]      mul_product,
    input  logic                   mul_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PROD_W-1:0]      out_product,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_err
);

    localparam int WORD_W = SIGN_MODE_W + 2*OP_W + TAG_W;

    ctrl_state_t state, state_nxt;

    logic [WORD_W-1:0]      fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [SIGN_MODE_W-1:0] head_mode;
    logic [OP_W-1:0]        head_a;
    logic [OP_W-1:0]        head_b;
    logic [TAG_W-1:0]       head_tag;

    // Operands as last issued; the core ignores them outside ISSUE.
    logic [OP_W-1:0]        mul_a_q;
    logic [OP_W-1:0]        mul_b_q;
    logic [SIGN_MODE_W-1:0] mul_mode_q;

    logic                   expire;

    assign in_ready = !fifo_full;
    assign {head_mode, head_a, head_b, head_tag} = fifo_rdata;

    booth_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata ({in_sign_mode, in_a, in_b, in_tag}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef BOOTH_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // Fires on the TIMEOUT_CYC-th WAIT cycle; a coincident done wins.
    assign expire  = (state == WAIT) && !mul_done && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign out_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if (state == WAIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == WAIT && mul_done) begin
            err_q <= 1'b0;
        end else if (expire) begin
            err_q <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign out_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (mul_done || expire) state_nxt = HOLD;
            HOLD:  if (out_ready) state_nxt = fifo_empty ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mul_start     = 1'b0;
        fifo_pop      = 1'b0;
        out_valid     = 1'b0;
        mul_a         = mul_a_q;
        mul_b         = mul_b_q;
        mul_sign_mode = mul_mode_q;
        case (state)
            ISSUE: begin
                mul_start     = 1'b1;
                fifo_pop      = 1'b1;
                mul_a         = head_a;
                mul_b         = head_b;
                mul_sign_mode = head_mode;
            end
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result and issued-operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_mode_q  <= '0;
            out_tag     <= '0;
            out_product <= '0;
        end else begin
            if (state == ISSUE) begin
                mul_a_q    <= head_a;
                mul_b_q    <= head_b;
                mul_mode_q <= head_mode;
                out_tag    <= head_tag;
            end
            if (state == WAIT && mul_done) begin
                out_product <= mul_product;
            end else if (expire) begin
                out_product <= '0;
            end
        end
    end

endmodule
